rr_mux4_arb: RTL
================

RR_MUX4_ARB -- requirements
Module: rr_mux4_arb

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant may be held (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req  input  4  request from requester i on bit i.
REQ-005 The block SHALL have ports I0, I1, I2, I3  input  4 each  data of requesters 0..3.
REQ-006 The block SHALL have port gnt  output  4  one-hot grant, registered.
REQ-007 The block SHALL have port s  output  2  index of current owner, registered; this drives the shared 4:1 selection.
REQ-008 The block SHALL have port o  output  4  registered selected data.
REQ-009 The block SHALL have port valid  output  1  o holds owner data.

Function
REQ-010 The block SHALL implement two states: IDLE (gnt=0) and BUSY (gnt=onehot(s)).
REQ-011 In IDLE with req!=0, the block SHALL grant the first set req bit searching from last+1 modulo 4 upward, where last is the index of the previous owner, and go to BUSY.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0.
REQ-013 Grant latency SHALL be 1 cycle: req sampled at edge n -> gnt/s updated at edge n.
REQ-014 o SHALL be registered as I[s] on every BUSY cycle, with valid=1 from the edge after the grant edge; data latency from grant is 1 cycle.
REQ-015 o SHALL hold its last value, and valid SHALL be 0, in the cycle after any IDLE cycle.
REQ-016 hold_cnt SHALL be cleared to 0 on every new grant and increment each BUSY cycle.
REQ-017 Release SHALL occur in BUSY when req[s]==0 or hold_cnt==MAX_HOLD-1.
REQ-018 On release with req!=0, the block SHALL regrant in the same edge using the search of REQ-011 with last=s (no idle gap); the current owner SHALL be eligible only as the last candidate.
REQ-019 On release with req==0, the block SHALL go to IDLE and set gnt=0; s SHALL retain the last owner.
REQ-020 Requests SHALL never preempt a held grant except by the MAX_HOLD limit.
REQ-021 The granted index SHALL be the only gnt bit set; gnt SHALL be 0 or one-hot in every cycle.
REQ-022 When MAX_HOLD=1, every BUSY cycle SHALL be a release, giving strict per-cycle rotation among active requesters.

Reset
REQ-023 While rst_n=0, the block SHALL immediately force: state=IDLE, gnt=0, s=0, last=3, hold_cnt=0, o=0, valid=0.
REQ-024 Reset asserted mid-grant SHALL abort the grant; after rst_n rises, the first grant SHALL search from index 0.
REQ-025 Reset deassertion SHALL be treated as synchronous-release; the first state update occurs on the first clk edge with rst_n=1.

Structure
REQ-026 A package rr_mux4_pkg SHALL hold: the state enum (IDLE, BUSY), N_REQ=4, the MAX_HOLD default, and the hold counter width (4).
REQ-027 One combinational sub-module rr_pick4 SHALL hold the rotating priority search, with inputs req[3:0] and last[1:0], and outputs any and idx[1:0].
REQ-028 The 4:1 data selection SHALL be inline, followed by the o register.

Verification
REQ-029 Reset scenario: rst_n=0 for 3 cycles with req=4'hF -> gnt=0, s=0, o=0, valid=0; after release, first gnt=4'b0001.
REQ-030 Round-robin scenario: req=4'hF held, I0=5, I1=A, I2=5, I3=A, MAX_HOLD=1 -> gnt sequence 1,2,4,8,1 on consecutive edges; o sequence 5,A,5,A lagging by 1 cycle.
REQ-031 Hold-limit scenario: req=4'b0011 constant, MAX_HOLD=8 -> gnt=0001 for exactly 8 cycles, then 0010 for 8 cycles, then 0001.
REQ-032 Early-release scenario: req0 high 3 cycles then low, with req2 pending -> gnt 0001 x3 then 0100 on the next edge with no gap; valid stays 1.
REQ-033 Idle scenario: single req1 pulse of 1 cycle -> gnt=0010 for 1 cycle, valid=1 for 1 cycle, then IDLE; the next req=4'hF grants index 2.
REQ-034 Mid-grant reset scenario: assert rst_n=0 asynchronously during BUSY with s=2 -> gnt=0 and valid=0 before the next clk edge; after release, req=4'hF grants index 0.

Source files
------------

// File: rtl/rr_mux4_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter/mux.
// Holds the FSM state encoding, requester count, hold-limit default and the one-hot helper.
package rr_mux4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int N_REQ        = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int HOLD_W       = 4;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux4_arb_pick4.sv
// Rotating-priority search: first set req bit starting at last+1 (mod 4),
// with index 'last' itself considered only after the other three.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        any  = |req;
        idx  = last;
        cand = last;
        // Walk from the lowest priority (offset 4 == last) up to last+1 so the
        // highest-priority hit is the final assignment.
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux4_arb.sv
// Round-robin arbiter over 4 requesters with a per-grant hold limit, driving a
// registered 4:1 data mux from the current owner index.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; gnt=0, s keeps previous owner, o holds, valid drops
// BUSY  | owner s holds the grant; o <= I[s] each cycle, valid=1 after 1st
module rr_mux4_arb
    import rr_mux4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] I0,
    input  logic [3:0] I1,
    input  logic [3:0] I2,
    input  logic [3:0] I3,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic [3:0] o,
    output logic       valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        s_q, s_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        o_q, o_d;
    logic              valid_q, valid_d;

    logic              pick_any;
    logic [1:0]        pick_idx;
    logic [3:0]        sel_data;
    logic              release_now;

    // last_q tracks s_q after the first grant; it differs only out of reset,
    // where the search must start from index 0.
    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_data = I0;
        case (s_q)
            2'd0: sel_data = I0;
            2'd1: sel_data = I1;
            2'd2: sel_data = I2;
            2'd3: sel_data = I3;
            default: sel_data = I0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        s_d         = s_q;
        last_d      = last_q;
        hold_d      = hold_q;
        o_d         = o_q;
        valid_d     = valid_q;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (pick_any) begin
                    state_d = BUSY;
                    s_d     = pick_idx;
                    last_d  = pick_idx;
                    gnt_d   = onehot4(pick_idx);
                    hold_d  = '0;
                end
            end
            BUSY: begin
                o_d         = sel_data;
                valid_d     = 1'b1;
                release_now = !req[s_q] || (hold_q == HOLD_LAST);
                if (release_now) begin
                    if (pick_any) begin
                        s_d    = pick_idx;
                        last_d = pick_idx;
                        gnt_d  = onehot4(pick_idx);
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            s_q     <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            o_q     <= o_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign o     = o_q;
    assign valid = valid_q;

endmodule
